// File: rtl/rob_pkg.sv
// Shared definitions for the re-order buffer.
//   ROB_DEPTH / ROB_PR_W / ROB_CDB_W : default sizing for rob_param
//   rob_entry_t                      : per-entry state (valid, ready, halt, T, Told)
//   RETIRE_NONE_TAG                  : all-ones filler for unused retire slots
//   wrap_add                         : ROB index addition modulo a power-of-2 depth
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 64;
  localparam int unsigned ROB_PR_W  = 7;
  localparam int unsigned ROB_CDB_W = 6;

  // Wide enough for any tag width; users slice the low PR_W bits.
  localparam logic [31:0] RETIRE_NONE_TAG = '1;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic                halt;
    logic [ROB_PR_W-1:0] t;
    logic [ROB_PR_W-1:0] told;
  } rob_entry_t;

  // depth must be a power of two, so the modulo reduces to a mask.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned depth);
    return (a + b) & (depth - 1);
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire selector for the re-order buffer.
// Looks at the RETIRE_W oldest entries (slot 0 = head) and takes the longest
// prefix that is allowed, valid and ready, stopping right after a halt.
//   slot_valid/ready/halt : state of the entries at head+i
//   slot_allow            : per-slot permission (halted flag, mispredict limit)
//   slot_en               : slot i retires this cycle
//   num                   : number of retiring entries
//   halt_out              : a halt entry is among the retiring ones
module rob_retire_sel #(
  parameter int RETIRE_W = 2,
  localparam int RN_W = $clog2(RETIRE_W + 1)
) (
  input  logic [RETIRE_W-1:0] slot_valid,
  input  logic [RETIRE_W-1:0] slot_ready,
  input  logic [RETIRE_W-1:0] slot_halt,
  input  logic [RETIRE_W-1:0] slot_allow,
  output logic [RETIRE_W-1:0] slot_en,
  output logic [RN_W-1:0]     num,
  output logic                halt_out
);

  logic go;

  always_comb begin
    slot_en  = '0;
    num      = '0;
    halt_out = 1'b0;
    go       = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (go && slot_allow[i] && slot_valid[i] && slot_ready[i]) begin
        slot_en[i] = 1'b1;
        num        = num + RN_W'(1);
        // Nothing younger than a halt may commit alongside it.
        if (slot_halt[i]) begin
          halt_out = 1'b1;
          go       = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised re-order buffer.
// Allocates up to DISPATCH_W entries per cycle at the tail, marks entries
// complete by ROB index from CDB_W channels, and retires up to RETIRE_W ready
// entries in order from the head, returning Told to the freelist and T to the
// architectural map table.
// Optional macro ROB_BRANCH_RECOVER_EN: when defined, br_mispredict rolls the
// tail back to br_rob_idx+1 and squashes younger entries; when undefined the
// branch inputs are ignored.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-low reset
//   id_dispatch_num       : entries dispatched this cycle (slot 0 first)
//   id_valid_inst         : per slot, 0 = entry enters already ready
//   id_halt               : per slot, entry is a halt
//   fl_pr, mt_told        : per slot new tag T and previous mapping Told
//   id_cap                : slots available (from registered count)
//   rob_idx               : index assigned to dispatch slot k (tail+k)
//   cdb_valid/cdb_rob_idx : completion channels
//   br_mispredict/br_rob_idx : squash everything younger than br_rob_idx
//   fl_retire_num         : entries retiring this cycle
//   fl_retire_told        : Told per retire slot, all-ones when unused
//   mt_retire_tag         : T per retire slot, all-ones when unused
//   retire_halt           : a halt retires this cycle
//   rob_count             : registered occupancy
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int DISPATCH_W = 2,
  parameter int RETIRE_W   = 2,
  parameter int CDB_W      = ROB_CDB_W,
  parameter int PR_W       = ROB_PR_W,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int NUM_W      = $clog2(DISPATCH_W + 1),
  localparam int RN_W      = $clog2(RETIRE_W + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_W-1:0]           id_dispatch_num,
  input  logic [DISPATCH_W-1:0]      id_valid_inst,
  input  logic [DISPATCH_W-1:0]      id_halt,
  input  logic [DISPATCH_W*PR_W-1:0] fl_pr,
  input  logic [DISPATCH_W*PR_W-1:0] mt_told,
  output logic [NUM_W-1:0]           id_cap,
  output logic [DISPATCH_W*IDX_W-1:0] rob_idx,
  input  logic [CDB_W-1:0]           cdb_valid,
  input  logic [CDB_W*IDX_W-1:0]     cdb_rob_idx,
  input  logic                       br_mispredict,
  input  logic [IDX_W-1:0]           br_rob_idx,
  output logic [RN_W-1:0]            fl_retire_num,
  output logic [RETIRE_W*PR_W-1:0]   fl_retire_told,
  output logic [RETIRE_W*PR_W-1:0]   mt_retire_tag,
  output logic                       retire_halt,
  output logic [IDX_W:0]             rob_count
);

  localparam logic [PR_W-1:0] NONE_TAG = RETIRE_NONE_TAG[PR_W-1:0];

  // Control state (reset) and entry payload (not reset).
  logic [DEPTH-1:0] valid_q, ready_q, halt_q;
  logic [PR_W-1:0]  t_q    [DEPTH];
  logic [PR_W-1:0]  told_q [DEPTH];
  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q;
  logic             halted_q;

  logic [IDX_W-1:0]    wp [DISPATCH_W];
  logic                disp_ok;
  logic [NUM_W-1:0]    disp_num;
  logic [IDX_W-1:0]    tail_d;
  logic [IDX_W:0]      count_d;

  logic                squash_act;
  logic [IDX_W-1:0]    squash_num;
  logic [DEPTH-1:0]    squash_mask;

  logic [IDX_W-1:0]    slot_ptr [RETIRE_W];
  logic [RETIRE_W-1:0] slot_valid, slot_ready, slot_halt, slot_allow, slot_en;
  logic [RN_W-1:0]     ret_num;
  logic                ret_halt;

  // Capacity uses only the registered count; this cycle's retires give no credit.
  always_comb begin
    if (32'(count_q) + 32'(DISPATCH_W) <= 32'(DEPTH)) id_cap = NUM_W'(DISPATCH_W);
    else                                               id_cap = NUM_W'(32'(DEPTH) - 32'(count_q));
  end

  for (genvar k = 0; k < DISPATCH_W; k++) begin : g_wp
    assign wp[k] = IDX_W'(wrap_add(32'(tail_q), k, DEPTH));
    assign rob_idx[k*IDX_W +: IDX_W] = wp[k];
  end

`ifdef ROB_BRANCH_RECOVER_EN
  logic [IDX_W-1:0] br_dist;

  assign squash_act = br_mispredict;
  assign br_dist    = br_rob_idx - head_q;
  // Entries br+1 .. tail-1; when full (tail==head) this still counts correctly.
  assign squash_num = tail_q - br_rob_idx - IDX_W'(1);

  for (genvar e = 0; e < DEPTH; e++) begin : g_sq
    logic [IDX_W-1:0] age;
    assign age            = IDX_W'(e) - br_rob_idx - IDX_W'(1);
    assign squash_mask[e] = squash_act && (age < squash_num);
  end

  for (genvar i = 0; i < RETIRE_W; i++) begin : g_allow
    // During a mispredict only the branch and older entries may retire.
    assign slot_allow[i] = !halted_q && (!squash_act || (IDX_W'(i) <= br_dist));
  end

  assign tail_d = squash_act ? br_rob_idx + IDX_W'(1) : tail_q + IDX_W'(disp_num);
`else
  logic unused_br;

  assign unused_br   = ^{br_mispredict, br_rob_idx};
  assign squash_act  = 1'b0;
  assign squash_num  = '0;
  assign squash_mask = '0;
  assign slot_allow  = {RETIRE_W{!halted_q}};
  assign tail_d      = tail_q + IDX_W'(disp_num);
`endif

  // An over-capacity request is dropped as a whole, as is any dispatch in a
  // mispredict cycle.
  assign disp_ok  = !squash_act && (id_dispatch_num <= id_cap);
  assign disp_num = disp_ok ? id_dispatch_num : '0;

  for (genvar i = 0; i < RETIRE_W; i++) begin : g_slot
    assign slot_ptr[i]   = IDX_W'(wrap_add(32'(head_q), i, DEPTH));
    assign slot_valid[i] = valid_q[slot_ptr[i]];
    assign slot_ready[i] = ready_q[slot_ptr[i]];
    assign slot_halt[i]  = halt_q[slot_ptr[i]];
    assign fl_retire_told[i*PR_W +: PR_W] = slot_en[i] ? told_q[slot_ptr[i]] : NONE_TAG;
    assign mt_retire_tag[i*PR_W +: PR_W]  = slot_en[i] ? t_q[slot_ptr[i]]    : NONE_TAG;
  end

  rob_retire_sel #(.RETIRE_W(RETIRE_W)) u_retire_sel (
    .slot_valid (slot_valid),
    .slot_ready (slot_ready),
    .slot_halt  (slot_halt),
    .slot_allow (slot_allow),
    .slot_en    (slot_en),
    .num        (ret_num),
    .halt_out   (ret_halt)
  );

  assign fl_retire_num = ret_num;
  assign retire_halt   = ret_halt;
  assign rob_count     = count_q;

  assign count_d = (IDX_W+1)'(32'(count_q) + 32'(disp_num) - 32'(ret_num) - 32'(squash_num));

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= '0;
      ready_q  <= '0;
      halt_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      assert (id_dispatch_num <= id_cap);
      // Later assignments win: retire and squash clears override completion.
      for (int c = 0; c < CDB_W; c++) begin
        if (cdb_valid[c] && valid_q[cdb_rob_idx[c*IDX_W +: IDX_W]])
          ready_q[cdb_rob_idx[c*IDX_W +: IDX_W]] <= 1'b1;
      end
      for (int i = 0; i < RETIRE_W; i++) begin
        if (slot_en[i]) begin
          valid_q[slot_ptr[i]] <= 1'b0;
          ready_q[slot_ptr[i]] <= 1'b0;
          halt_q[slot_ptr[i]]  <= 1'b0;
        end
      end
      for (int e = 0; e < DEPTH; e++) begin
        if (squash_mask[e]) begin
          valid_q[e] <= 1'b0;
          ready_q[e] <= 1'b0;
          halt_q[e]  <= 1'b0;
        end
      end
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (k < int'(disp_num)) begin
          valid_q[wp[k]] <= 1'b1;
          ready_q[wp[k]] <= ~id_valid_inst[k];
          halt_q[wp[k]]  <= id_halt[k];
        end
      end
      head_q  <= head_q + IDX_W'(ret_num);
      tail_q  <= tail_d;
      count_q <= count_d;
      if (ret_halt) halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (k < int'(disp_num)) begin
        t_q[wp[k]]    <= fl_pr[k*PR_W +: PR_W];
        told_q[wp[k]] <= mt_told[k*PR_W +: PR_W];
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the buffer (oldest entry at the queue front).
module tb_rob_param;
  import rob_pkg::*;

  localparam int D  = 64;
  localparam int DW = 2;
  localparam int RW = 2;
  localparam int CW = 6;
  localparam int PW = 7;
  localparam int IW = 6;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [1:0]     id_dispatch_num;
  logic [DW-1:0]  id_valid_inst, id_halt;
  logic [DW*PW-1:0] fl_pr, mt_told;
  logic [1:0]     id_cap;
  logic [DW*IW-1:0] rob_idx;
  logic [CW-1:0]  cdb_valid;
  logic [CW*IW-1:0] cdb_rob_idx;
  logic           br_mispredict;
  logic [IW-1:0]  br_rob_idx;
  logic [1:0]     fl_retire_num;
  logic [RW*PW-1:0] fl_retire_told, mt_retire_tag;
  logic           retire_halt;
  logic [IW:0]    rob_count;

  rob_param dut (
    .clock(clock), .reset(reset),
    .id_dispatch_num(id_dispatch_num), .id_valid_inst(id_valid_inst), .id_halt(id_halt),
    .fl_pr(fl_pr), .mt_told(mt_told), .id_cap(id_cap), .rob_idx(rob_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .br_mispredict(br_mispredict), .br_rob_idx(br_rob_idx),
    .fl_retire_num(fl_retire_num), .fl_retire_told(fl_retire_told),
    .mt_retire_tag(mt_retire_tag), .retire_halt(retire_halt), .rob_count(rob_count)
  );

  always #5 clock = ~clock;

  rob_entry_t mq[$];
  int  m_head;
  bit  m_halted;
  int  n_cmp, n_fail;
  int  pr_ctr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_cap();
    return (D - mq.size() < DW) ? D - mq.size() : DW;
  endfunction

  // Compare every output against the model for the current inputs, then
  // advance the model by the clock edge that follows.
  task automatic model_step();
    int cap, tail, brpos, j, keep, p;
    bit mp, hret, go;
    cap  = model_cap();
    tail = (m_head + mq.size()) % D;
    chk("id_cap", 32'(id_cap), cap);
    chk("rob_count", 32'(rob_count), mq.size());
    for (int k = 0; k < DW; k++) chk("rob_idx", 32'(rob_idx[k*IW +: IW]), (tail + k) % D);
    mp = 1'b0;
    brpos = D;
`ifdef ROB_BRANCH_RECOVER_EN
    if (br_mispredict) begin
      mp = 1'b1;
      brpos = (int'(br_rob_idx) - m_head + D) % D;
    end
`endif
    j = 0; hret = 1'b0; go = !m_halted;
    for (int s = 0; s < RW; s++) begin
      if (go && s < mq.size() && s <= brpos && mq[s].ready) begin
        j++;
        if (mq[s].halt) begin hret = 1'b1; go = 1'b0; end
      end else go = 1'b0;
    end
    chk("fl_retire_num", 32'(fl_retire_num), j);
    chk("retire_halt", 32'(retire_halt), 32'(hret));
    for (int s = 0; s < RW; s++) begin
      chk("fl_retire_told", 32'(fl_retire_told[s*PW +: PW]), (s < j) ? 32'(mq[s].told) : 32'h7f);
      chk("mt_retire_tag", 32'(mt_retire_tag[s*PW +: PW]), (s < j) ? 32'(mq[s].t) : 32'h7f);
    end
    for (int c = 0; c < CW; c++) begin
      if (cdb_valid[c]) begin
        p = (int'(cdb_rob_idx[c*IW +: IW]) - m_head + D) % D;
        if (p < mq.size()) mq[p].ready = 1'b1;
      end
    end
    repeat (j) void'(mq.pop_front());
    m_head = (m_head + j) % D;
    if (hret) m_halted = 1'b1;
    if (mp) begin
      keep = brpos + 1 - j;
      while (mq.size() > keep) void'(mq.pop_back());
    end else if (int'(id_dispatch_num) <= cap) begin
      for (int k = 0; k < int'(id_dispatch_num); k++)
        mq.push_back('{valid: 1'b1, ready: ~id_valid_inst[k], halt: id_halt[k],
                       t: fl_pr[k*PW +: PW], told: mt_told[k*PW +: PW]});
    end
  endtask

  task automatic idle();
    id_dispatch_num = '0; id_valid_inst = '0; id_halt = '0;
    fl_pr = '0; mt_told = '0; cdb_valid = '0; cdb_rob_idx = '0;
    br_mispredict = 1'b0; br_rob_idx = '0;
  endtask

  task automatic tick();
    @(negedge clock);
    if (reset) model_step();
    else begin mq.delete(); m_head = 0; m_halted = 1'b0; end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    pr_ctr = 0;
  endtask

  // Told of each new entry = running counter + 1, T = Told + 64 (mod 128).
  task automatic disp(input int n, input logic [1:0] vi, input logic [1:0] hl);
    id_dispatch_num = 2'(n);
    id_valid_inst = vi;
    id_halt = hl;
    for (int k = 0; k < DW; k++) begin
      mt_told[k*PW +: PW] = PW'(pr_ctr + k + 1);
      fl_pr[k*PW +: PW]   = PW'(pr_ctr + k + 1 + 64);
    end
    pr_ctr += n;
  endtask

  task automatic cdb(input int ch, input int idx);
    cdb_valid[ch] = 1'b1;
    cdb_rob_idx[ch*IW +: IW] = IW'(idx);
  endtask

  initial begin
    int n, cap;
    bit filling;
    n_cmp = 0; n_fail = 0;
    m_head = 0; m_halted = 1'b0; pr_ctr = 0;

    // Reset values
    do_reset();
    chk("reset id_cap", 32'(id_cap), 2);
    chk("reset fl_retire_num", 32'(fl_retire_num), 0);
    chk("reset fl_retire_told", 32'(fl_retire_told), 32'h3fff);
    chk("reset mt_retire_tag", 32'(mt_retire_tag), 32'h3fff);
    chk("reset retire_halt", 32'(retire_halt), 0);
    chk("reset rob_count", 32'(rob_count), 0);

    // Steady stream of ready entries
    for (int i = 0; i < 32; i++) begin
      disp(2, 2'b00, 2'b00);
      tick();
      if (i == 5 || i == 31) begin
        chk("stream rob_count", 32'(rob_count), 2);
        chk("stream fl_retire_num", 32'(fl_retire_num), 2);
      end
    end
    idle(); tick();
    chk("stream drained", 32'(rob_count), 0);

    // Fill to full, then free one slot
    do_reset();
    for (int i = 0; i < 32; i++) begin disp(2, 2'b11, 2'b00); tick(); end
    idle();
    chk("full rob_count", 32'(rob_count), 64);
    chk("full id_cap", 32'(id_cap), 0);
    cdb(0, 0); tick(); idle();
    chk("full retire num", 32'(fl_retire_num), 1);
    chk("full retire told0", 32'(fl_retire_told[PW-1:0]), 1);
    chk("full retire told1", 32'(fl_retire_told[2*PW-1:PW]), 32'h7f);
    tick();
    chk("full id_cap after", 32'(id_cap), 1);

    // Out-of-order completion, in-order retire
    do_reset();
    disp(2, 2'b11, 2'b00); tick(); idle();
    cdb(3, 1); tick(); idle();
    chk("ooo no retire", 32'(fl_retire_num), 0);
    cdb(1, 0); tick(); idle();
    chk("ooo retire num", 32'(fl_retire_num), 2);
    chk("ooo told0", 32'(fl_retire_told[PW-1:0]), 1);
    chk("ooo told1", 32'(fl_retire_told[2*PW-1:PW]), 2);
    tick();

    // Halt at index 3
    do_reset();
    disp(2, 2'b00, 2'b00); tick();
    disp(2, 2'b00, 2'b10); tick();
    disp(2, 2'b00, 2'b00);
    chk("halt retire_halt", 32'(retire_halt), 1);
    chk("halt retire num", 32'(fl_retire_num), 2);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      chk("halted retire_halt", 32'(retire_halt), 0);
      chk("halted retire num", 32'(fl_retire_num), 0);
      tick();
    end
    chk("halted rob_count", 32'(rob_count), 2);

    // Mispredict with wrapped pointers: head=60, tail=4
    do_reset();
    for (int i = 0; i < 30; i++) begin disp(2, 2'b00, 2'b00); tick(); end
    idle(); tick();
    for (int i = 0; i < 4; i++) begin disp(2, 2'b11, 2'b00); tick(); end
    idle();
    chk("pre-br rob_count", 32'(rob_count), 8);
    chk("pre-br tail", 32'(rob_idx[IW-1:0]), 4);
    disp(2, 2'b11, 2'b00);
    br_mispredict = 1'b1; br_rob_idx = 6'd62;
    tick(); idle();
`ifdef ROB_BRANCH_RECOVER_EN
    chk("br rob_count", 32'(rob_count), 3);
    chk("br tail", 32'(rob_idx[IW-1:0]), 63);
`else
    chk("br rob_count", 32'(rob_count), 10);
    chk("br tail", 32'(rob_idx[IW-1:0]), 6);
`endif
    cdb(0, 1); cdb(1, 60); cdb(2, 61); cdb(3, 62);
    tick(); idle(); tick(); tick();
`ifdef ROB_BRANCH_RECOVER_EN
    chk("br drained", 32'(rob_count), 0);
`else
    chk("br drained", 32'(rob_count), 7);
`endif

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      filling = ((cyc / 150) % 2) == 0;
      cap = model_cap();
      n = filling ? cap : int'($urandom_range(0, cap));
      disp(n, 2'($urandom), 2'b00);
      for (int c = 0; c < CW; c++) begin
        if (filling ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0)) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            cdb(c, (m_head + int'($urandom_range(0, mq.size() - 1))) % D);
          else
            cdb(c, int'($urandom_range(0, D - 1)));
        end
      end
      if (mq.size() > 0 && $urandom_range(0, 31) == 0) begin
        br_mispredict = 1'b1;
        br_rob_idx = IW'((m_head + int'($urandom_range(0, mq.size() - 1))) % D);
      end
      tick();
    end
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
